dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined MIPS core's MEM stage. Accepts load/store requests from the EX/MEM register outputs, holds the pipeline with a stall until the access completes after a fixed latency, then returns load data. Keeps sticky error status and access counters for the end-of-run statistics printout.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_dmem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        resp_valid;
  logic        err;
  logic [31:0] read_count;
  logic [31:0] write_count;

  modport master (
    output mem_read, mem_write, addr, write_data,
    input  read_data, mem_stall, resp_valid, err, read_count, write_count
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data,
    output read_data, mem_stall, resp_valid, err, read_count, write_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: stalls the pipeline for LATENCY cycles per access,
// returns load data for one cycle, and keeps sticky error status plus saturating access counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L    = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
  localparam bit          MULTI_CYC  = (LATENCY > 1);
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_rd_q, is_rd_d;
  logic              is_wr_q, is_wr_d;
  logic              bad_q, bad_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              err_q, err_d;
  logic [31:0]       read_count_q, read_count_d;
  logic [31:0]       write_count_q, write_count_d;

  logic [31:0]       mem [DEPTH_WORDS];

  // Request decode; the 32-bit subtract makes addresses below the base wrap to huge indices.
  logic              req;
  logic [31:0]       offset;
  logic [31:0]       word_idx;
  logic              req_bad;

  assign req      = bus.mem_read | bus.mem_write;
  assign offset   = bus.addr - BASE_ADDR;
  assign word_idx = offset >> 2;
  assign req_bad  = (bus.addr[1:0] != 2'b00)
                  | (word_idx >= DEPTH_L)
                  | (bus.mem_read & bus.mem_write);

  // When LATENCY==1 the access enters DONE straight from IDLE, before anything is latched.
  logic              src_from_req;
  logic [IDX_W-1:0]  src_idx;
  logic              src_rd;
  logic              src_bad;
  logic              enter_done;

  assign src_from_req = (state_q == IDLE);
  assign src_idx      = src_from_req ? word_idx[IDX_W-1:0] : idx_q;
  assign src_rd       = src_from_req ? bus.mem_read        : is_rd_q;
  assign src_bad      = src_from_req ? req_bad             : bad_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    is_rd_d       = is_rd_q;
    is_wr_d       = is_wr_q;
    bad_d         = bad_q;
    err_d         = err_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    read_data_d   = 32'h0;
    resp_valid_d  = 1'b0;
    enter_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = word_idx[IDX_W-1:0];
          wdata_d = bus.write_data;
          is_rd_d = bus.mem_read;
          is_wr_d = bus.mem_write & ~bus.mem_read;
          bad_d   = req_bad;
          cnt_d   = CNT_INIT;
          if (MULTI_CYC) begin
            state_d = BUSY;
          end else begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      BUSY: begin
        // A dropped request aborts the access; a changed one is ignored.
        if (!req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_rd_q && (read_count_q != CNT_MAX)) read_count_d = read_count_q + 32'd1;
        if (is_wr_q && (write_count_q != CNT_MAX)) write_count_d = write_count_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    // Response outputs are registered, so they are computed on the edge entering DONE.
    if (enter_done) begin
      resp_valid_d = 1'b1;
      if (src_bad) begin
        err_d = 1'b1;
      end else if (src_rd) begin
        read_data_d = mem[src_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      idx_q         <= '0;
      wdata_q       <= 32'h0;
      is_rd_q       <= 1'b0;
      is_wr_q       <= 1'b0;
      bad_q         <= 1'b0;
      read_data_q   <= 32'h0;
      resp_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      read_count_q  <= 32'h0;
      write_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      is_rd_q       <= is_rd_d;
      is_wr_q       <= is_wr_d;
      bad_q         <= bad_d;
      read_data_q   <= read_data_d;
      resp_valid_q  <= resp_valid_d;
      err_q         <= err_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // Stores commit on the edge leaving DONE; state_q is reset asynchronously, so no write under reset.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; a reset port would prevent RAM inference.
    if ((state_q == DONE) && is_wr_q && !bad_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Stall is combinational so the hazard unit freezes the pipe in the request's first cycle.
  assign bus.mem_stall   = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign bus.read_data   = read_data_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.err         = err_q;
  assign bus.read_count  = read_count_q;
  assign bus.write_count = write_count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the functional scenarios and a
// LATENCY=1 instance for the randomized store/load sweep against a reference array.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic        got;
    int          stalls;
    int          cycles;
    logic [31:0] rdata;
    logic        err;
    logic        stall_at_resp;
  } acc_t;

  logic clk;
  logic rst1, rst2;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.write_data = wd;
    end else begin
      bus2.mem_read = rd; bus2.mem_write = wr; bus2.addr = a; bus2.write_data = wd;
    end
  endtask

  // Called at posedge+1; presents a request, samples on falling edges until the response, then
  // withdraws it at posedge+1 of the following cycle (so consecutive calls run back-to-back).
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, output acc_t r);
    logic rv, st;
    r.got = 1'b0; r.stalls = 0; r.cycles = 0; r.rdata = 32'hx; r.err = 1'bx; r.stall_at_resp = 1'bx;
    drive(sel, rd, wr, a, wd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r.cycles++;
      rv = sel ? bus1.resp_valid : bus2.resp_valid;
      st = sel ? bus1.mem_stall  : bus2.mem_stall;
      if (rv === 1'b1) begin
        r.got           = 1'b1;
        r.rdata         = sel ? bus1.read_data : bus2.read_data;
        r.err           = sel ? bus1.err       : bus2.err;
        r.stall_at_resp = st;
        break;
      end
      if (st === 1'b1) r.stalls++;
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus2.read_data, bus2.mem_stall, bus2.resp_valid, bus2.err, bus2.read_count, bus2.write_count} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: rd=%h stall=%b rv=%b err=%b rc=%0d wc=%0d, want all 0",
                 i, bus2.read_data, bus2.mem_stall, bus2.resp_valid, bus2.err, bus2.read_count, bus2.write_count);
      end
    end
    checks++;
    if ({bus1.read_data, bus1.mem_stall, bus1.resp_valid, bus1.err, bus1.read_count, bus1.write_count} !== '0) begin
      errors++;
      $display("FAIL reset_idle_lat1: outputs not all 0 (stall=%b rv=%b err=%b)", bus1.mem_stall, bus1.resp_valid, bus1.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load;
    acc_t r;
    access(1'b0, 1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, r);
    checks++;
    if (!(r.got === 1'b1 && r.stalls == 2 && r.cycles == 3 && r.stall_at_resp === 1'b0 && r.err === 1'b0)) begin
      errors++;
      $display("FAIL store_timing: got=%b stalls=%0d cycles=%0d stall_at_resp=%b err=%b, want 1/2/3/0/0",
               r.got, r.stalls, r.cycles, r.stall_at_resp, r.err);
    end
    access(1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, r);
    checks++;
    if (!(r.got === 1'b1 && r.stalls == 2 && r.cycles == 3 && r.stall_at_resp === 1'b0)) begin
      errors++;
      $display("FAIL load_timing: got=%b stalls=%0d cycles=%0d stall_at_resp=%b, want 1/2/3/0",
               r.got, r.stalls, r.cycles, r.stall_at_resp);
    end
    checks++;
    if (r.rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_data: got %h want deadbeef", r.rdata);
    end
    @(negedge clk);
    checks++;
    if (!(bus2.resp_valid === 1'b0 && bus2.read_data === 32'h0 && bus2.mem_stall === 1'b0)) begin
      errors++;
      $display("FAIL after_done: rv=%b rd=%h stall=%b, want 0/0/0", bus2.resp_valid, bus2.read_data, bus2.mem_stall);
    end
    checks++;
    if (!(bus2.read_count === 32'd1 && bus2.write_count === 32'd1 && bus2.err === 1'b0)) begin
      errors++;
      $display("FAIL counts_store_load: rc=%0d wc=%0d err=%b, want 1/1/0", bus2.read_count, bus2.write_count, bus2.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_errors;
    acc_t r;
    logic [31:0] err_addr [4];
    logic [1:0]  err_type [4];   // {read, write}
    err_addr[0] = 32'h1000_0002; err_type[0] = 2'b10;
    err_addr[1] = 32'h0FFF_FFFC; err_type[1] = 2'b10;
    err_addr[2] = 32'h1000_0010; err_type[2] = 2'b11;
    err_addr[3] = 32'h1000_1000; err_type[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, err_type[i][1], err_type[i][0], err_addr[i], 32'h5555_5555, r);
      checks++;
      if (!(r.got === 1'b1 && r.stalls == 2 && r.cycles == 3 && r.rdata === 32'h0 && r.err === 1'b1)) begin
        errors++;
        $display("FAIL error_access %0d (%h): got=%b stalls=%0d cycles=%0d rd=%h err=%b, want 1/2/3/0/1",
                 i, err_addr[i], r.got, r.stalls, r.cycles, r.rdata, r.err);
      end
    end
    access(1'b0, 1'b0, 1'b1, 32'h1000_0FFC, 32'hA5A5_0001, r);
    access(1'b0, 1'b1, 1'b0, 32'h1000_0FFC, 32'h0, r);
    checks++;
    if (!(r.rdata === 32'hA5A5_0001 && r.err === 1'b1)) begin
      errors++;
      $display("FAIL last_word: rd=%h err=%b, want a5a50001 with sticky err 1", r.rdata, r.err);
    end
    access(1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, r);
    checks++;
    if (r.rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL unchanged_after_errors: got %h want deadbeef", r.rdata);
    end
    checks++;
    if (!(bus2.read_count === 32'd6 && bus2.write_count === 32'd3)) begin
      errors++;
      $display("FAIL counts_errors: rc=%0d wc=%0d, want 6/3", bus2.read_count, bus2.write_count);
    end
  endtask

  task automatic test_abort;
    acc_t r;
    access(1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'h0BAD_F00D, r);
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'h0000_1234);
    @(negedge clk);
    checks++;
    if (bus2.mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL abort_first_stall: stall=%b want 1", bus2.mem_stall);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus2.mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_stall: stall=%b want 1", bus2.mem_stall);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (!(bus2.mem_stall === 1'b0 && bus2.resp_valid === 1'b0 && bus2.read_data === 32'h0)) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: stall=%b rv=%b rd=%h, want 0/0/0", i, bus2.mem_stall, bus2.resp_valid, bus2.read_data);
      end
    end
    checks++;
    if (bus2.write_count !== 32'd4) begin
      errors++;
      $display("FAIL abort_write_count: got %0d want 4", bus2.write_count);
    end
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 1'b0, 32'h1000_0020, 32'h0, r);
    checks++;
    if (r.rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL abort_no_commit: got %h want 0badf00d", r.rdata);
    end
    checks++;
    if (bus2.read_count !== 32'd7) begin
      errors++;
      $display("FAIL abort_read_count: got %0d want 7", bus2.read_count);
    end
  endtask

  task automatic test_reset_mid;
    acc_t r;
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'hFFFF_0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus2.mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_stall: stall=%b want 1", bus2.mem_stall);
    end
    #1;
    rst2 = 1'b1;
    #1;
    checks++;
    if (!(bus2.resp_valid === 1'b0 && bus2.err === 1'b0 && bus2.read_data === 32'h0 &&
          bus2.read_count === 32'h0 && bus2.write_count === 32'h0 && bus2.mem_stall === 1'b1)) begin
      errors++;
      $display("FAIL async_reset: rv=%b err=%b rd=%h rc=%0d wc=%0d stall=%b, want 0/0/0/0/0/1",
               bus2.resp_valid, bus2.err, bus2.read_data, bus2.read_count, bus2.write_count, bus2.mem_stall);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus2.mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_no_req: stall=%b want 0", bus2.mem_stall);
    end
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    access(1'b0, 1'b1, 1'b0, 32'h1000_0020, 32'h0, r);
    checks++;
    if (!(r.got === 1'b1 && r.rdata === 32'h0BAD_F00D && r.err === 1'b0)) begin
      errors++;
      $display("FAIL reset_drops_store: got=%b rd=%h err=%b, want 1/0badf00d/0", r.got, r.rdata, r.err);
    end
    checks++;
    if (!(bus2.read_count === 32'd1 && bus2.write_count === 32'd0)) begin
      errors++;
      $display("FAIL counts_after_reset: rc=%0d wc=%0d, want 1/0", bus2.read_count, bus2.write_count);
    end
  endtask

  task automatic test_back_to_back;
    acc_t r1, r2;
    time  t0;
    t0 = $time;
    access(1'b0, 1'b0, 1'b1, 32'h1000_0030, 32'h1357_9BDF, r1);
    access(1'b0, 1'b1, 1'b0, 32'h1000_0030, 32'h0, r2);
    checks++;
    if (!(r1.cycles == 3 && r2.cycles == 3 && ($time - t0) == 60)) begin
      errors++;
      $display("FAIL b2b_rate: cycles=%0d,%0d span=%0t, want 3,3 span 60", r1.cycles, r2.cycles, $time - t0);
    end
    checks++;
    if (r2.rdata !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL b2b_data: got %h want 13579bdf", r2.rdata);
    end
    checks++;
    if (!(bus2.read_count === 32'd2 && bus2.write_count === 32'd1)) begin
      errors++;
      $display("FAIL b2b_counts: rc=%0d wc=%0d, want 2/1", bus2.read_count, bus2.write_count);
    end
  endtask

  task automatic test_latency1_sweep;
    acc_t        r;
    logic [31:0] model [logic [31:0]];
    logic [31:0] waddr [$];
    logic [31:0] a, d, la;
    for (int i = 0; i < 100; i++) begin
      a = BASE + (32'($urandom_range(0, 1023)) << 2);
      d = $urandom;
      access(1'b1, 1'b0, 1'b1, a, d, r);
      model[a] = d;
      waddr.push_back(a);
      checks++;
      if (!(r.got === 1'b1 && r.stalls == 1 && r.cycles == 2 && r.stall_at_resp === 1'b0 && r.err === 1'b0)) begin
        errors++;
        $display("FAIL lat1_store %0d @%h: got=%b stalls=%0d cycles=%0d err=%b, want 1/1/2/0",
                 i, a, r.got, r.stalls, r.cycles, r.err);
      end
      la = waddr[$urandom_range(0, waddr.size() - 1)];
      access(1'b1, 1'b1, 1'b0, la, 32'h0, r);
      checks++;
      if (!(r.got === 1'b1 && r.stalls == 1 && r.cycles == 2 && r.rdata === model[la])) begin
        errors++;
        $display("FAIL lat1_load %0d @%h: got=%b stalls=%0d cycles=%0d rd=%h, want 1/1/2/%h",
                 i, la, r.got, r.stalls, r.cycles, r.rdata, model[la]);
      end
    end
    checks++;
    if (!(bus1.read_count === 32'd100 && bus1.write_count === 32'd100 && bus1.err === 1'b0)) begin
      errors++;
      $display("FAIL lat1_counts: rc=%0d wc=%0d err=%b, want 100/100/0", bus1.read_count, bus1.write_count, bus1.err);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_latency1_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
